// File: rtl/mul_36_241_recon.sv
// mul_36_241_recon: reconstructs a 36-bit dividend x = q*241 + r, one quotient nibble per cycle
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake (q[31:0], r[7:0]) accepted in IDLE only
//   out_valid/out_ready  : result handshake; x[35:0] and err held while stalled
//   err                  : illegal remainder or 36-bit overflow, built only with MUL_241_RANGE_CHECK_EN
module mul_36_241_recon (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] q,
  input  logic [7:0]  r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [35:0] x,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [11:0] T [16] = '{12'd0, 12'd241, 12'd482, 12'd723, 12'd964, 12'd1205,
                                     12'd1446, 12'd1687, 12'd1928, 12'd2169, 12'd2410,
                                     12'd2651, 12'd2892, 12'd3133, 12'd3374, 12'd3615};
  state_t      state_q, state_d;
  logic [31:0] q_q, q_d;
  logic [7:0]  r_q, r_d;
  logic [39:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  d;
  logic        last;
  // {~cnt,2'b11} == 31-4*cnt: MSB nibble first
  assign d         = q_q[{~cnt_q, 2'b11} -: 4];
  assign last      = cnt_q == 3'd7;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign x         = acc_q[35:0];
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      q_d     = q;
      r_d     = r;
      acc_d   = '0;
      cnt_d   = '0;
    end
    if (state_q == RUN) begin
      acc_d   = {acc_q[35:0], 4'd0} + {28'd0, T[d]} + {32'd0, last ? r_q : 8'd0};
      cnt_d   = cnt_q + 3'd1;
      state_d = last ? DONE : RUN;
    end
    if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef MUL_241_RANGE_CHECK_EN
  assign err = out_valid && (r_q > 8'd240 || |acc_q[39:36]);
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_mul_36_241_recon.sv
// tb_mul_36_241_recon: directed-vector bench for mul_36_241_recon
module tb_mul_36_241_recon;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [31:0] q = 0;
  logic [7:0]  r = 0;
  logic        in_ready, out_valid, err;
  logic [35:0] x;
  int n_chk = 0, n_pass = 0;
`ifdef MUL_241_RANGE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  mul_36_241_recon dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .q(q), .r(r),
                        .out_valid(out_valid), .out_ready(out_ready), .x(x), .err(err));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [31:0] qv, input logic [7:0] rv, input int hold,
                        input logic [35:0] ex, input logic ee);
    int lat;
    chk("ready_before", 64'(in_ready), 1);
    in_valid = 1; q = qv; r = rv;
    tick;
    in_valid = 0; q = 32'hDEADBEEF; r = 8'hFF;
    lat = 1;
    while (!out_valid && lat < 30) begin
      chk("busy_not_ready", 64'(in_ready), 0);
      tick;
      lat++;
    end
    chk("latency", 64'(lat), 9);
    chk("x", 64'(x), 64'(ex));
    chk("err", 64'(err), 64'(ee));
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_valid", 64'(out_valid), 1);
      chk("hold_x", 64'(x), 64'(ex));
      chk("hold_ready", 64'(in_ready), 0);
    end
    out_ready = 1;
    tick;
    out_ready = 0;
    chk("consumed_valid", 64'(out_valid), 0);
    chk("consumed_err", 64'(err), 0);
    chk("idle_ready", 64'(in_ready), 1);
  endtask
  initial begin
    int n;
    tick; tick;
    chk("rst_ready", 64'(in_ready), 1);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_x", 64'(x), 0);
    chk("rst_err", 64'(err), 0);
    rst = 0;
    tick;
    chk("post_rst_ready", 64'(in_ready), 1);
    run_op(32'd1, 8'd5, 0, 36'd246, 1'b0);
    run_op(32'd285143056, 8'd239, 0, 36'hFFFFFFFFF, 1'b0);
    run_op(32'd285143056, 8'd240, 0, 36'd0, CHK);
    run_op(32'hFFFFFFFF, 8'd0, 0, 36'h0FFFFFF0F, CHK);
    run_op(32'd0, 8'd0, 3, 36'd0, 1'b0);
    run_op(32'd1000, 8'd0, 1, 36'd241000, 1'b0);
    run_op(32'd12345678, 8'd17, 0, 36'd2975308415, 1'b0);
    in_valid = 1; q = 32'd1000; r = 8'd0;
    tick;
    in_valid = 0;
    tick; tick; tick;
    rst = 1;
    tick;
    rst = 0;
    chk("abort_ready", 64'(in_ready), 1);
    chk("abort_valid", 64'(out_valid), 0);
    chk("abort_x", 64'(x), 0);
    for (int i = 0; i < 12; i++) tick;
    chk("abort_no_result", 64'(out_valid), 0);
    run_op(32'd1000, 8'd0, 0, 36'd241000, 1'b0);
    in_valid = 1; q = 32'd7; r = 8'd3;
    tick;
    n = 1;
    while (!out_valid && n < 30) begin
      q = q + 32'd2; r = r + 8'd1;
      tick;
      n++;
    end
    chk("stream_lat", 64'(n), 9);
    chk("stream_x0", 64'(x), 64'd1690);
    q = 32'd11; r = 8'd1; out_ready = 1;
    tick;
    out_ready = 0;
    n = 1;
    chk("stream_no_turnaround", 64'(in_ready), 1);
    tick;
    q = 32'd99; r = 8'd50;
    n++;
    while (!out_valid && n < 40) begin
      tick;
      n++;
    end
    in_valid = 0;
    chk("stream_gap", 64'(n), 10);
    chk("stream_x1", 64'(x), 64'd2652);
    out_ready = 1;
    tick;
    out_ready = 0;
    chk("stream_idle", 64'(in_ready), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
